// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO sequencer.
// Optional build macro MMIO_ALIGN_CHECK_EN is consumed by mmio_addr_decode.
package mmio_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_DMEM, REG_SW, REG_LED} region_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [63:0] DMEM_BASE_DEF = 64'h0000_0000;
  localparam logic [63:0] DMEM_SIZE_DEF = 64'h0000_0200;
  localparam logic [63:0] SW_BASE_DEF   = 64'h0000_0400;
  localparam logic [63:0] SW_SIZE_DEF   = 64'h0000_0004;
  localparam logic [63:0] LED_BASE_DEF  = 64'h0000_0500;
  localparam logic [63:0] LED_SIZE_DEF  = 64'h0000_0004;

  // base <= addr < base+size, written so that base+size can never wrap
  function automatic logic in_region(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational region decode and legality check for one CPU access.
// Macro MMIO_ALIGN_CHECK_EN: when defined, non word-aligned accesses are illegal.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter logic [63:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [63:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [63:0] SW_BASE   = SW_BASE_DEF,
  parameter logic [63:0] SW_SIZE   = SW_SIZE_DEF,
  parameter logic [63:0] LED_BASE  = LED_BASE_DEF,
  parameter logic [63:0] LED_SIZE  = LED_SIZE_DEF
) (
  input  logic [63:0] addr_i,
  input  logic        we_i,
  output region_e     region_o,
  output logic        illegal_o
);

  // Region match, then reject unmapped, stores to switches and loads from LEDs
  always_comb begin
    region_o = REG_NONE;
    if (in_region(addr_i, DMEM_BASE, DMEM_SIZE)) begin
      region_o = REG_DMEM;
    end else if (in_region(addr_i, SW_BASE, SW_SIZE)) begin
      region_o = REG_SW;
    end else if (in_region(addr_i, LED_BASE, LED_SIZE)) begin
      region_o = REG_LED;
    end
    illegal_o = (region_o == REG_NONE) ||
                ((region_o == REG_SW)  &&  we_i) ||
                ((region_o == REG_LED) && !we_i);
`ifdef MMIO_ALIGN_CHECK_EN
    if (addr_i[1:0] != 2'b00) begin
      illegal_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Sequencer between the CPU load/store port and the memory-mapped targets
// (data memory, switches, LEDs). One request in flight; every output is a
// register. Build macro MMIO_ALIGN_CHECK_EN (see mmio_addr_decode) rejects
// misaligned accesses.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [63:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [63:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [63:0] SW_BASE   = SW_BASE_DEF,
  parameter logic [63:0] SW_SIZE   = SW_SIZE_DEF,
  parameter logic [63:0] LED_BASE  = LED_BASE_DEF,
  parameter logic [63:0] LED_SIZE  = LED_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        sw_re,
  output logic [63:0] sw_addr,
  input  logic [31:0] sw_rdata,
  output logic        led_we,
  output logic [31:0] led_wdata
);

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  logic        we_q, we_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        dmem_re_q, dmem_re_d;
  logic        dmem_we_q, dmem_we_d;
  logic [63:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        sw_re_q, sw_re_d;
  logic [63:0] sw_addr_q, sw_addr_d;
  logic        led_we_q, led_we_d;
  logic [31:0] led_wdata_q, led_wdata_d;

  region_e     dec_region;
  logic        dec_illegal;

  // Decode the live request; it is only acted on in IDLE, the cycle it is latched
  mmio_addr_decode #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE),
    .SW_BASE   (SW_BASE),
    .SW_SIZE   (SW_SIZE),
    .LED_BASE  (LED_BASE),
    .LED_SIZE  (LED_SIZE)
  ) u_decode (
    .addr_i    (cpu_addr),
    .we_i      (cpu_we),
    .region_o  (dec_region),
    .illegal_o (dec_illegal)
  );

  // Next state and next output values; outputs are registered, so the values
  // computed here appear during the state being entered
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    we_d         = we_q;
    ld_data_d    = ld_data_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    dmem_re_d    = 1'b0;
    dmem_we_d    = 1'b0;
    sw_re_d      = 1'b0;
    led_we_d     = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    sw_addr_d    = sw_addr_q;
    led_wdata_d  = led_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d     = cpu_we;
          region_d = dec_region;
          if (dec_illegal) begin
            // Error response goes straight out, no target is touched
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ISSUE;
            case (dec_region)
              REG_DMEM: begin
                dmem_re_d    = !cpu_we;
                dmem_we_d    = cpu_we;
                dmem_addr_d  = cpu_addr - DMEM_BASE;
                dmem_wdata_d = cpu_wdata;
              end
              REG_SW: begin
                sw_re_d   = 1'b1;
                sw_addr_d = cpu_addr - SW_BASE;
              end
              REG_LED: begin
                led_we_d    = 1'b1;
                led_wdata_d = cpu_wdata;
              end
              default: ;
            endcase
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
          ack_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Target read data is valid now, one cycle after its read enable
        ld_data_d = (region_q == REG_SW) ? sw_rdata : dmem_rdata;
        rdata_d   = ld_data_d;
        ack_d     = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        // After the ack, show the last loaded word again
        state_d = IDLE;
        rdata_d = ld_data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      region_q     <= REG_NONE;
      we_q         <= 1'b0;
      ld_data_q    <= 32'h0;
      rdata_q      <= 32'h0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      dmem_re_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 64'h0;
      dmem_wdata_q <= 32'h0;
      sw_re_q      <= 1'b0;
      sw_addr_q    <= 64'h0;
      led_we_q     <= 1'b0;
      led_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      we_q         <= we_d;
      ld_data_q    <= ld_data_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      dmem_re_q    <= dmem_re_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      sw_re_q      <= sw_re_d;
      sw_addr_q    <= sw_addr_d;
      led_we_q     <= led_we_d;
      led_wdata_q  <= led_wdata_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ack    = ack_q;
  assign cpu_err    = err_q;
  assign dmem_re    = dmem_re_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign sw_re      = sw_re_q;
  assign sw_addr    = sw_addr_q;
  assign led_we     = led_we_q;
  assign led_wdata  = led_wdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed testbench for mmio_ctrl with simple registered target models.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [63:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        dmem_re;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        sw_re;
  logic [63:0] sw_addr;
  logic [31:0] sw_rdata;
  logic        led_we;
  logic [31:0] led_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sw_val;
  logic [31:0] mem [0:127];

  int en_cnt    = 0;
  int multi_cnt = 0;
  int ack_cnt   = 0;

  mmio_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .sw_re      (sw_re),
    .sw_addr    (sw_addr),
    .sw_rdata   (sw_rdata),
    .led_we     (led_we),
    .led_wdata  (led_wdata)
  );

  always #5 clk = ~clk;

  // Registered target models: read data valid one cycle after the enable
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[8:2]] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= mem[dmem_addr[8:2]];
    if (sw_re)   sw_rdata   <= sw_val;
  end

  // Enable / ack activity counters
  always @(negedge clk) begin
    if (!rst) begin
      en_cnt  <= en_cnt + int'(dmem_re) + int'(dmem_we) + int'(sw_re) + int'(led_we);
      ack_cnt <= ack_cnt + int'(cpu_ack);
      if ((int'(dmem_re) + int'(dmem_we) + int'(sw_re) + int'(led_we)) > 1)
        multi_cnt <= multi_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access; returns latency, response and a snapshot of cycle 1
  task automatic access(input logic we, input logic [63:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic [3:0] en1, output logic [63:0] da1,
                        output logic [63:0] sa1, output logic [31:0] wd1);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; err = 1'bx; rd = 'x; en1 = 'x; da1 = 'x; sa1 = 'x; wd1 = 'x;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        en1 = {dmem_re, dmem_we, sw_re, led_we};
        da1 = dmem_addr; sa1 = sw_addr;
        wd1 = we ? (led_we ? led_wdata : dmem_wdata) : 32'h0;
        cpu_addr = ~addr; cpu_wdata = ~wd;
      end
      if (cpu_ack) begin
        lat = i; err = cpu_err; rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    tick();
    check("ack_one_cycle", {63'h0, cpu_ack}, 64'h0);
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  logic [3:0]  en1;
  logic [63:0] da1, sa1;
  logic [31:0] wd1;
  int          en_before, ack_before;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'h0; cpu_wdata = 32'h0;
    sw_val = 32'h0000_A5C3;
    tick(); tick();
    check("rst_ack",   {63'h0, cpu_ack}, 64'h0);
    check("rst_rdata", {32'h0, cpu_rdata}, 64'h0);
    check("rst_en",    {60'h0, dmem_re, dmem_we, sw_re, led_we}, 64'h0);
    check("rst_addr",  dmem_addr | sw_addr, 64'h0);
    rst = 1'b0;
    tick();

    // Switches load
    access(1'b0, 64'h400, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
    check("sw_ld_en1",  {60'h0, en1}, 64'h2);
    check("sw_ld_addr", sa1, 64'h0);
    check("sw_ld_lat",  lat, 3);
    check("sw_ld_err",  {63'h0, err}, 64'h0);
    check("sw_ld_data", {32'h0, rd}, 64'h0000_A5C3);
    check("sw_ld_en_after", {60'h0, dmem_re, dmem_we, sw_re, led_we}, 64'h0);
    check("rdata_hold", {32'h0, cpu_rdata}, 64'h0000_A5C3);

    // LED store
    access(1'b1, 64'h500, 32'h0000_00FF, lat, err, rd, en1, da1, sa1, wd1);
    check("led_st_en1",  {60'h0, en1}, 64'h1);
    check("led_st_data", {32'h0, wd1}, 64'hFF);
    check("led_st_lat",  lat, 2);
    check("led_st_err",  {63'h0, err}, 64'h0);
    check("led_st_rd0",  {32'h0, rd}, 64'h0);

    // DMEM store then load
    access(1'b1, 64'h10, 32'hDEAD_BEEF, lat, err, rd, en1, da1, sa1, wd1);
    check("dm_st_en1",  {60'h0, en1}, 64'h4);
    check("dm_st_addr", da1, 64'h10);
    check("dm_st_wd",   {32'h0, wd1}, 64'hDEAD_BEEF);
    check("dm_st_lat",  lat, 2);
    access(1'b0, 64'h10, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
    check("dm_ld_en1",  {60'h0, en1}, 64'h8);
    check("dm_ld_addr", da1, 64'h10);
    check("dm_ld_lat",  lat, 3);
    check("dm_ld_data", {32'h0, rd}, 64'hDEAD_BEEF);

    // Illegal accesses
    en_before = en_cnt;
    access(1'b1, 64'h400, 32'h1234_5678, lat, err, rd, en1, da1, sa1, wd1);
    check("ill_sw_st_lat", lat, 1);
    check("ill_sw_st_err", {63'h0, err}, 64'h1);
    check("ill_sw_st_rd",  {32'h0, rd}, 64'h0);
    access(1'b0, 64'h500, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
    check("ill_led_ld_lat", lat, 1);
    check("ill_led_ld_err", {63'h0, err}, 64'h1);
    check("ill_led_ld_rd",  {32'h0, rd}, 64'h0);
    access(1'b0, 64'h800, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
    check("ill_unmap_lat", lat, 1);
    check("ill_unmap_err", {63'h0, err}, 64'h1);
    check("ill_unmap_rd",  {32'h0, rd}, 64'h0);
    check("ill_no_enable", en_cnt, en_before);

    // Reset during WAIT of a switches load
    sw_val = 32'h0000_5A5A;
    cpu_we = 1'b0; cpu_addr = 64'h400; cpu_wdata = 32'h0; cpu_req = 1'b1;
    tick();
    check("rst_mid_issue", {63'h0, sw_re}, 64'h1);
    tick();
    ack_before = ack_cnt;
    #2 rst = 1'b1; cpu_req = 1'b0;
    #1;
    check("rst_async_ack",   {63'h0, cpu_ack}, 64'h0);
    check("rst_async_rdata", {32'h0, cpu_rdata}, 64'h0);
    check("rst_async_en",    {60'h0, dmem_re, dmem_we, sw_re, led_we}, 64'h0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("rst_no_ack", ack_cnt, ack_before);
    access(1'b0, 64'h400, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
    check("post_rst_lat",  lat, 3);
    check("post_rst_data", {32'h0, rd}, 64'h0000_5A5A);

    // Misaligned load from switches
    en_before = en_cnt;
    access(1'b0, 64'h402, 32'h0, lat, err, rd, en1, da1, sa1, wd1);
`ifdef MMIO_ALIGN_CHECK_EN
    check("align_lat",  lat, 1);
    check("align_err",  {63'h0, err}, 64'h1);
    check("align_no_en", en_cnt, en_before);
`else
    check("align_lat",  lat, 3);
    check("align_err",  {63'h0, err}, 64'h0);
    check("align_addr", sa1, 64'h2);
    check("align_data", {32'h0, rd}, 64'h0000_5A5A);
`endif

    check("one_hot_enables", multi_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
Sequencer between the single-cycle CPU load/store port and the memory-mapped targets: data memory, the switches peripheral and the LED register. It latches one CPU request and decodes the address to a region. It then drives the selected target's enables for exactly one cycle, waits out the target's registered read latency and returns data with a one-cycle ack. Unmapped and illegal accesses return an error instead of touching any target.

Parameters:
DMEM_BASE, 64'h0000_0000, byte base of data memory region
DMEM_SIZE, 64'h0000_0200, byte span of data memory (512 B)
SW_BASE, 64'h0000_0400, byte base of switches region
SW_SIZE, 64'h0000_0004, byte span of switches region (one 32-bit word; read-only)
LED_BASE, 64'h0000_0500, byte base of LED region
LED_SIZE, 64'h0000_0004, byte span of LED region (write-only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  access request; held high until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  64  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid while cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  error flag, valid while cpu_ack = 1
dmem_re / dmem_we  out  1  data memory enables
dmem_addr  out  64  offset = cpu_addr - DMEM_BASE
dmem_wdata  out  32  store data
dmem_rdata  in  32  registered read data, valid one cycle after dmem_re
sw_re  out  1  switches readEnable
sw_addr  out  64  offset = cpu_addr - SW_BASE
sw_rdata  in  32  registered switches read data, valid one cycle after sw_re
led_we  out  1  LED write enable
led_wdata  out  32  LED data

Behaviour:
- Reset: all outputs 0, state IDLE, latched request cleared. Asserting rst mid-transaction aborts it. No ack is issued, enables drop immediately, and the state returns to IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when cpu_req = 1 (cycle N), latch we, addr and wdata, and decode the region. Region match is base <= addr < base+size; the regions never overlap.
  - Legal access: go to ISSUE.
  - Illegal access: go to RESP with err = 1 and rdata = 0. Illegal means no region match, a store to SW, or a load from LED.
- ISSUE (cycle N+1): exactly one target enable high for this single cycle. Offset addr and wdata are driven from the latched values. Load goes to WAIT; store goes to RESP.
- WAIT (cycle N+2): capture the selected target's rdata into cpu_rdata; go to RESP.
- RESP: cpu_ack = 1 for one cycle, cpu_err as decoded, then IDLE.
- Latencies (req seen to ack high):
  - load: N+3
  - store: N+2
  - error: N+1
- cpu_rdata holds its value after ack until the next load capture. Error and store responses drive cpu_rdata = 0 during ack.
- cpu_req is ignored in ISSUE, WAIT and RESP. A new request is sampled only in IDLE, so the earliest back-to-back acceptance is the cycle after RESP.
- Enables are never asserted in IDLE, WAIT or RESP. At most one enable is high in any cycle.
- Changes to cpu_addr or cpu_wdata after acceptance have no effect; only the latched copy is used.
- Offsets use 64-bit wrap-free subtraction; a match guarantees a non-negative offset.

Optional Feature:
MMIO_ALIGN_CHECK_EN
- Defined: an access with addr[1:0] != 2'b00 is illegal, and the error path is taken with no target enable.
- Undefined: misaligned addresses pass through unchanged, and the target handles byte offsets itself.

Decomposition:
- Package mmio_pkg:
  - region enum: REG_NONE, REG_DMEM, REG_SW, REG_LED
  - state enum: IDLE, ISSUE, WAIT, RESP
  - default base/size constants
- Sub-module mmio_addr_decode: combinational. Inputs addr and we; outputs region and illegal flag. It is instantiated once inside mmio_ctrl and unit-testable alone.

Test Plan:
- Switches load: sw_rdata = 32'h0000_A5C3, load addr 64'h400 at cycle 0 -> sw_re high in cycle 1 only, sw_addr = 0, cpu_ack at cycle 3 with cpu_rdata = 32'h0000_A5C3 and cpu_err = 0.
- LED store: addr 64'h500, wdata 32'h0000_00FF -> led_we pulse in cycle 1 with led_wdata = 32'hFF, ack at cycle 2, err = 0.
- DMEM store then load: store 32'hDEAD_BEEF at 64'h10, then load 64'h10 -> dmem_addr = 64'h10 both times, load returns 32'hDEAD_BEEF.
- Illegal accesses: store to 64'h400, load from 64'h500, load from 64'h800 -> each acks at cycle 1 with err = 1, rdata = 0, and no enable ever high.
- Reset mid-load: assert rst during WAIT -> outputs 0 asynchronously, no ack. After release, a load from 64'h400 completes normally with 3-cycle latency.
- Alignment with macro defined: load from 64'h402 -> err = 1 at cycle 1, sw_re never asserted. Without the macro the same load -> sw_addr = 2, normal 3-cycle ack.
